nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle W-bit adder that streams two wide operands, one nibble per clock, through the team's existing 4-bit ripple adder. A registered carry chains the nibbles together. It sits directly upstream of `fullAdder_4bit`: it latches the operands, feeds that adder one nibble at a time, and collects its sum/cout back into a result register. A start/busy/done handshake lets a controller issue wide additions with only a single 4-bit adder in hardware.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES (default 16); must be ≥ 1.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new addition; sampled on a rising edge.
- `a`  in  W  operand A; sampled only on an accepted start.
- `b`  in  W  operand B; sampled only on an accepted start.
- `cin`  in  1  carry-in to nibble 0; sampled only on an accepted start.
- `busy`  out  1  high while an addition is in progress.
- `done`  out  1  one-cycle pulse: `sum`/`cout` are valid.
- `sum`  out  W  registered result; holds until the next accepted start.
- `cout`  out  1  registered carry-out of the top nibble.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states:
  - IDLE:
    - `start`=1 → latch `a`, `b` into shift registers and `cin` into the carry flop.
    - Clear `sum` to 0 and the nibble counter to 0.
    - Go to RUN.
  - RUN, every cycle:
    - The adder sees the low nibble of A_sh, the low nibble of B_sh, and the carry flop.
    - The 4-bit adder sum is shifted into `sum` from the MSB side; `sum` shifts right by 4.
    - The carry flop takes the adder cout.
    - A_sh and B_sh shift right by 4; the counter increments.
    - When the counter reaches NIBBLES-1 (last nibble), also load `cout` from the adder cout and go to DONE.
  - DONE:
    - `done`=1 for exactly this one cycle.
    - `start`=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- `busy` = (state == RUN).
- `start` while in RUN is ignored: no latch, no error.
- Result: {`cout`, `sum`} = `a` + `b` + `cin`, computed modulo 2^(W+1).
- Counter width is $clog2(NIBBLES) with a minimum of 1 bit. For NIBBLES=1, RUN lasts one cycle.
- Input changes on `a`/`b`/`cin` during RUN have no effect.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Counter, shift registers and carry flop = 0.
- Release is synchronous in effect: the first active edge after `rst_n` rises may accept `start`.
- Latency: `start` accepted at edge 0 → `busy`=1 after edges 0..NIBBLES-1. At edge NIBBLES, `sum`/`cout` are final and `done`=1 for one cycle.
- Throughput: one addition every NIBBLES+1 cycles when `start` is held high. `start` is re-accepted in the DONE cycle, so there is no IDLE gap.
- Reset asserted mid-RUN aborts the operation immediately:
  - All outputs return to their reset values.
  - No `done` is generated for the aborted operation.
- `sum` is not valid while `busy`=1: it holds the partial shift contents.
- `sum`/`cout` are stable from the `done` cycle until the next accepted start.

## Structure
- Shared package `adder_pkg`:
  - FSM state typedef (IDLE, RUN, DONE).
  - Constant NIBBLE_W = 4.
- One sub-module: instantiate the existing `fullAdder_4bit` as the per-nibble datapath.
- All sequencing, shift registers, the carry flop and the counter live in `nibble_serial_adder`.

## Test plan
- Reset, then `start` with `a`=0x0000, `b`=0x0000, `cin`=1 → `done` 4 cycles after start; `sum`=0x0001, `cout`=0.
- `a`=0xFFFF, `b`=0x0001, `cin`=0 → `sum`=0x0000, `cout`=1 (carry ripples through all four nibbles). Then `a`=0x1234, `b`=0x4321, `cin`=0 → `sum`=0x5555, `cout`=0.
- `a`=0xFFFF, `b`=0xFFFF, `cin`=1 → `sum`=0xFFFF, `cout`=1. Also check `busy` is high for exactly 4 cycles and `done` is a 1-cycle pulse.
- Pulse `start` with different operands two cycles after an accepted start → ignored. The result matches the first operands only, with exactly one `done`.
- Hold `start`=1 continuously with 0x00FF+0x0001, then 0x8000+0x8000 → `done` every 5 cycles. Results are 0x0100/`cout`=0, then 0x0000/`cout`=1.
- Assert `rst_n`=0 mid-RUN (cycle 2) → `busy`, `done`, `sum`, `cout` go to 0 asynchronously and no `done` follows. A new start after release completes correctly.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/fullAdder_4bit.sv
// 4-bit ripple-carry adder: the single per-nibble datapath shared by the serial adder.
module fullAdder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands one nibble per clock through a single 4-bit adder,
// chaining slices with a registered carry.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Handshake: start is taken only in IDLE or DONE; busy marks the NIBBLES RUN cycles;
    // done pulses for one cycle with sum/cout final, and they hold until the next accept.
    state_t          state, state_nx;
    logic [W-1:0]    a_sh, b_sh, sum_next;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [3:0]      fa_sum;
    logic            fa_cout;
    logic            accept, last;

    fullAdder_4bit u_fa (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(NIBBLES - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // New nibble enters at the MSB so the low slice lands at bit 0 after the last shift.
    if (NIBBLES == 1) begin : g_one
        assign sum_next = fa_sum;
    end else begin : g_many
        assign sum_next = {fa_sum, sum[W-1:NIBBLE_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            sum   <= sum_next;
            if (last) cout <= fa_cout;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: driver pushes a+b+cin, a negedge monitor checks on done.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_len = 0;
    logic prev_done = 1'b0;

    logic [W:0] exp_q[$];
    int         due_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present operands with start high; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        start = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, ia} + {1'b0, ib} + (W+1)'(ic));
        due_q.push_back(cyc + N);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout actual=%0d pending required=0 pending", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, (W+1)'(busy), '0);
        check({tag, "_done"}, (W+1)'(done), '0);
        check({tag, "_sum"},  (W+1)'(sum),  '0);
        check({tag, "_cout"}, (W+1)'(cout), '0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) run_len++;
            if (done) begin
                check("done_pulse_width", (W+1)'(prev_done), '0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done sum=%h", sum);
                end else begin
                    check("result", {cout, sum}, exp_q.pop_front());
                    check("latency", (W+1)'(cyc), (W+1)'(due_q.pop_front()));
                    check("busy_cycles", (W+1)'(run_len), (W+1)'(N));
                end
                run_len = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed cases, including full carry ripple and all-ones.
        launch(16'h0000, 16'h0000, 1'b1); start = 1'b0; wait_idle();
        launch(16'hFFFF, 16'h0001, 1'b0); start = 1'b0; wait_idle();
        launch(16'h1234, 16'h4321, 1'b0); start = 1'b0; wait_idle();
        launch(16'hFFFF, 16'hFFFF, 1'b1); start = 1'b0; wait_idle();

        // Start pulse during RUN must be ignored.
        launch(16'hA5A5, 16'h0F0F, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h7777; b = 16'h1111; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (8) @(posedge clk);
        #1;

        // Back-to-back with start held high: done every N+1 cycles.
        launch(16'h00FF, 16'h0001, 1'b0);
        repeat (N) @(posedge clk);
        #1;
        launch(16'h8000, 16'h8000, 1'b0);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-RUN aborts without a done.
        launch(16'h1111, 16'h2222, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        due_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        launch(16'h0F0F, 16'hF0F1, 1'b1); start = 1'b0; wait_idle();

        // Randomized operands, mixing idle gaps and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = '1;
            launch(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat (N) @(posedge clk);
                #1;
                launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            end
            start = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
